vae_io_ctrl: RTL and testbench
==============================

VAE_IO_CTRL -- requirements
Module: vae_io_ctrl

Interface
REQ-001 Parameter WIDTH, 16, bit width of one data lane.
REQ-002 Parameter BUS_W, 64, stream and readback word width; SHALL be a multiple of WIDTH.
REQ-003 Parameter N_IN, 76, number of lanes loaded into the core input buffer.
REQ-004 Parameter N_OUT, 9, number of core result lanes captured.
REQ-005 Parameter TIMEOUT, 255, maximum number of RUN cycles to wait for core_valid.
REQ-006 Derived: LPW = BUS_W/WIDTH; IN_DEPTH = ceil(N_IN/LPW); OUT_DEPTH = ceil(N_OUT/LPW); RA_W = max(1, clog2(OUT_DEPTH)).
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  pulse; begins a load/compute job.
REQ-010 in_valid  input  1  stream word valid.
REQ-011 in_ready  output  1  stream word accepted when in_valid && in_ready.
REQ-012 in_data  input  BUS_W  stream word.
REQ-013 core_in  output  N_IN*WIDTH  flattened lanes to core; lane k at [k*WIDTH +: WIDTH].
REQ-014 core_start  output  1  one-cycle compute request.
REQ-015 core_valid  input  1  core result valid.
REQ-016 core_out  input  N_OUT*WIDTH  flattened core results, same lane order.
REQ-017 busy  output  1  high in LOAD and RUN.
REQ-018 done  output  1  level; high in DONE.
REQ-019 error  output  1  timeout flag for the last job.
REQ-020 rd_en, rd_addr  input  1, RA_W  readback request and word address.
REQ-021 rd_data  output  BUS_W  readback word; rd_valid  output  1  qualifies rd_data.

Function
REQ-022 FSM states: IDLE, LOAD, RUN, DONE; reset state is IDLE.
REQ-023 IDLE/DONE + start -> LOAD: word count = 0, error cleared, done cleared; start is ignored in LOAD and RUN.
REQ-024 in_ready = 1 only in LOAD; each accepted word writes input word slot [count], then count increments.
REQ-025 Lane k of core_in = input word k/LPW, bits [(k%LPW)*WIDTH +: WIDTH]; lanes packed LSB first; padding lanes of the last word are discarded.
REQ-026 The word accepted when count = IN_DEPTH-1 -> RUN on the next edge; core_start is high for exactly the first RUN cycle.
REQ-027 core_in is stable from the end of LOAD through RUN and DONE, and changes only on accepted writes.
REQ-028 In RUN: core_valid -> capture core_out into the output buffer, -> DONE. core_valid in the core_start cycle is legal.
REQ-029 The RUN cycle counter starts at 0; reaching TIMEOUT without core_valid -> error = 1, -> DONE, output buffer unchanged.
REQ-030 core_valid outside RUN is ignored.
REQ-031 Output word j, lane l = result lane j*LPW+l at [l*WIDTH +: WIDTH]; unused lanes of the last word read 0.
REQ-032 Readback is permitted in any state: rd_data and rd_valid are registered one cycle after rd_en; rd_addr >= OUT_DEPTH returns 0 with rd_valid = 1; rd_valid = 0 when rd_en is low.
REQ-033 When a capture and a read of the same word fall in the same cycle, the read returns the old value.

Reset
REQ-034 rst_n low -> IDLE; in_ready, core_start, busy, done, error, rd_valid, rd_data, word count and timeout counter = 0; input and output buffers cleared to 0.
REQ-035 Reset asserted mid-LOAD or mid-RUN aborts the job; no core_start is issued after release until a new start.

Structure
REQ-036 Package vae_io_pkg holds the state enum and the LPW/depth/clog2 helper functions.
REQ-037 Sub-module lane_word_buf holds depth-parameterised BUS_W storage with a write counter and flattened lane output; it is instantiated for the input buffer.

Verification
REQ-038 Default parameters: start, 19 words with lane k = k+1 -> core_in lane 0 = 1, lane 75 = 76; core_start pulses once, 1 cycle after the 19th accept.
REQ-039 in_valid toggled every other cycle during LOAD -> only handshaked words are stored; still exactly 19 accepts before RUN.
REQ-040 core_valid 5 cycles after core_start with lanes 0x0101..0x0109 -> rd_addr 2 returns 0x0000_0000_0000_0109; rd_addr 3 returns 0.
REQ-041 core_valid never asserted -> error = 1 and done = 1 after 255 RUN cycles; readback shows the previous results.
REQ-042 rst_n pulsed low after 7 words -> IDLE, outputs 0; new start followed by 19 words completes normally.
REQ-043 WIDTH = 8, N_IN = 10, N_OUT = 3 -> 2 input words, 1 output word; lane mapping per REQ-025 and REQ-031.

Source files
------------

// File: rtl/vae_io_pkg.sv
// Shared types and sizing helpers for the VAE core I/O controller.
package vae_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int unsigned calc_lpw(input int unsigned bus_w, input int unsigned width);
    return bus_w / width;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  // Address/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lane_word_buf.sv
// Word-addressed lane buffer: bus words written in order, exposed as a flat lane vector.
module lane_word_buf
  import vae_io_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned BUS_W   = 64,
  parameter int unsigned DEPTH   = 19,
  parameter int unsigned N_LANES = 76,
  localparam int unsigned CNT_W  = clog2_min1(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [BUS_W-1:0]           wr_data,
  output logic [CNT_W-1:0]           count,
  output logic [N_LANES*WIDTH-1:0]   lanes
);

  localparam int unsigned LPW = calc_lpw(BUS_W, WIDTH);

  // Write pointer saturates at DEPTH so extra writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_en && (count < CNT_W'(DEPTH))) begin
      count <= count + CNT_W'(1);
    end
  end

  // Only real lanes are stored; padding lanes of the last word are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_LANES; k++) begin
        if (count == CNT_W'(k / LPW)) begin
          lanes[k*WIDTH +: WIDTH] <= wr_data[(k % LPW)*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/vae_io_ctrl.sv
// Streams input words into the VAE core, launches a compute, captures results
// with a timeout, and serves word readback of the captured results.
module vae_io_ctrl
  import vae_io_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned BUS_W     = 64,
  parameter int unsigned N_IN      = 76,
  parameter int unsigned N_OUT     = 9,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned LPW       = calc_lpw(BUS_W, WIDTH),
  localparam int unsigned OUT_DEPTH = ceil_div(N_OUT, LPW),
  localparam int unsigned RA_W      = clog2_min1(OUT_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUS_W-1:0]         in_data,
  output logic [N_IN*WIDTH-1:0]    core_in,
  output logic                     core_start,
  input  logic                     core_valid,
  input  logic [N_OUT*WIDTH-1:0]   core_out,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  input  logic                     rd_en,
  input  logic [RA_W-1:0]          rd_addr,
  output logic [BUS_W-1:0]         rd_data,
  output logic                     rd_valid
);

  localparam int unsigned IN_DEPTH = ceil_div(N_IN, LPW);
  localparam int unsigned IN_CW    = clog2_min1(IN_DEPTH + 1);
  localparam int unsigned TO_W     = clog2_min1(TIMEOUT + 1);

  state_e                     state_q;
  state_e                     next_state;
  logic [IN_CW-1:0]           in_count;
  logic [TO_W-1:0]            run_cnt_q;
  logic [N_OUT*WIDTH-1:0]     res_q;
  logic [OUT_DEPTH*BUS_W-1:0] res_pad_c;
  logic [BUS_W-1:0]           rd_word_c;
  logic                       accept_c;
  logic                       job_start_c;
  logic                       timeout_c;
  logic                       capture_c;

  lane_word_buf #(
    .WIDTH   (WIDTH),
    .BUS_W   (BUS_W),
    .DEPTH   (IN_DEPTH),
    .N_LANES (N_IN)
  ) u_in_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (job_start_c),
    .wr_en   (accept_c),
    .wr_data (in_data),
    .count   (in_count),
    .lanes   (core_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // in_ready is registered as (state == LOAD), so in_valid alone qualifies an accept here.
  always_comb begin
    next_state  = state_q;
    accept_c    = 1'b0;
    job_start_c = 1'b0;
    timeout_c   = 1'b0;
    capture_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state  = ST_LOAD;
          job_start_c = 1'b1;
        end
      end
      ST_LOAD: begin
        accept_c = in_valid;
        if (in_valid && (in_count == IN_CW'(IN_DEPTH - 1))) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_valid) begin
          capture_c  = 1'b1;
          next_state = ST_DONE;
        end else if (run_cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_c  = 1'b1;
          next_state = ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Result words zero-padded to whole bus words, then selected by address.
  always_comb begin
    res_pad_c                    = '0;
    res_pad_c[N_OUT*WIDTH-1:0]   = res_q;
    rd_word_c                    = '0;
    for (int j = 0; j < OUT_DEPTH; j++) begin
      if (rd_addr == RA_W'(j)) begin
        rd_word_c = res_pad_c[j*BUS_W +: BUS_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_start <= 1'b0;
      error      <= 1'b0;
      run_cnt_q  <= '0;
    end else begin
      in_ready   <= (next_state == ST_LOAD);
      busy       <= (next_state == ST_LOAD) || (next_state == ST_RUN);
      done       <= (next_state == ST_DONE);
      core_start <= (state_q == ST_LOAD) && (next_state == ST_RUN);
      run_cnt_q  <= (state_q == ST_RUN) ? run_cnt_q + TO_W'(1) : '0;
      if (job_start_c) begin
        error <= 1'b0;
      end else if (timeout_c) begin
        error <= 1'b1;
      end
    end
  end

  // Readback samples the pre-capture contents when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (capture_c) begin
        res_q <= core_out;
      end
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_word_c : '0;
    end
  end

endmodule

// File: tb/tb_vae_io_ctrl.sv
// Scoreboard bench for vae_io_ctrl: default configuration plus a narrow-lane instance.
module tb_vae_io_ctrl;

  localparam int W   = 16;
  localparam int BW  = 64;
  localparam int NI  = 76;
  localparam int NO  = 9;
  localparam int LPW = 4;
  localparam int IND = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, in_valid, in_ready, core_start, core_valid;
  logic              busy, done, error, rd_en, rd_valid;
  logic [BW-1:0]     in_data, rd_data;
  logic [NI*W-1:0]   core_in;
  logic [NO*W-1:0]   core_out;
  logic [1:0]        rd_addr;

  logic              s_start, s_in_valid, s_in_ready, s_core_start, s_core_valid;
  logic              s_busy, s_done, s_error, s_rd_en, s_rd_valid;
  logic [BW-1:0]     s_in_data, s_rd_data;
  logic [79:0]       s_core_in;
  logic [23:0]       s_core_out;
  logic [0:0]        s_rd_addr;

  vae_io_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .core_in(core_in), .core_start(core_start), .core_valid(core_valid),
    .core_out(core_out), .busy(busy), .done(done), .error(error), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  vae_io_ctrl #(.WIDTH(8), .BUS_W(64), .N_IN(10), .N_OUT(3), .TIMEOUT(255)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .core_in(s_core_in), .core_start(s_core_start),
    .core_valid(s_core_valid), .core_out(s_core_out), .busy(s_busy), .done(s_done),
    .error(s_error), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int cs_cnt  = 0;
  logic [15:0] exp_in  [NI];
  logic [15:0] exp_res [NO];
  logic [63:0] sb_q [$];

  // Handshake/pulse counters and readback scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_cnt++;
      if (core_start) cs_cnt++;
      if (rd_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: rd_valid=1 data=%h, required no readback", rd_data);
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          if (rd_data !== e) begin
            n_fail++;
            $display("FAIL rd_data: got %h, expected %h", rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] res_word(input int j);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < LPW; l++) if (j*LPW + l < NO) v[l*W +: W] = exp_res[j*LPW + l];
    return v;
  endfunction

  function automatic logic [NI*W-1:0] exp_core_in();
    logic [NI*W-1:0] v;
    for (int k = 0; k < NI; k++) v[k*W +: W] = exp_in[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [63:0] e);
    rd_en = 1'b1;
    rd_addr = a;
    sb_q.push_back(e);
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL rd_timeout addr=%0d: no rd_valid, expected data %h", a, e);
      sb_q.delete();
    end
  endtask

  // Idle for gap cycles, then hold in_valid until the word is accepted.
  task automatic send_word(input logic [63:0] wd, input int gap);
    bit acc;
    in_valid = 1'b0;
    in_data = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data = wd;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b0;
    in_data = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic load_job(input int base, input int gap, input bit poke, input int nw, input bit do_start);
    logic [63:0] wd;
    if (do_start) begin
      start = 1'b1; tick(); start = 1'b0;
    end
    for (int w = 0; w < nw; w++) begin
      if (poke && w == 5) begin
        start = 1'b1; tick(); start = 1'b0;
      end
      wd = '0;
      for (int l = 0; l < LPW; l++) begin
        int k;
        k = w*LPW + l;
        wd[l*W +: W] = 16'(base + k);
        if (k < NI) exp_in[k] = 16'(base + k);
      end
      send_word(wd, gap);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; in_valid = 0; in_data = '0; core_valid = 0; core_out = '0;
    rd_en = 0; rd_addr = '0;
    s_start = 0; s_in_valid = 0; s_in_data = '0; s_core_valid = 0; s_core_out = '0;
    s_rd_en = 0; s_rd_addr = '0;
    for (int k = 0; k < NI; k++) exp_in[k] = '0;
    for (int k = 0; k < NO; k++) exp_res[k] = '0;
    repeat (3) tick();
    n_tests++;
    if ({in_ready, core_start, busy, done, error, rd_valid} !== 6'b0 || rd_data !== '0 || core_in !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/cs/busy/done/err/rdv=%b rd_data=%h, required all 0",
               {in_ready, core_start, busy, done, error, rd_valid}, rd_data);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
    do_read(2'd0, 64'h0);
    do_read(2'd3, 64'h0);
  endtask

  task automatic test_load_basic();
    int a0, c0;
    a0 = acc_cnt; c0 = cs_cnt;
    load_job(1, 0, 1'b0, IND, 1'b1);
    n_tests++;
    if (core_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL core_start_timing: core_start=%b busy=%b after last accept, required 1 1", core_start, busy);
    end
    n_tests++;
    if (core_in[15:0] !== 16'd1 || core_in[75*W +: W] !== 16'd76 || core_in !== exp_core_in()) begin
      n_fail++;
      $display("FAIL core_in_basic: lane0=%h lane75=%h, required 0001 004c", core_in[15:0], core_in[75*W +: W]);
    end
    tick();
    n_tests++;
    if (core_start !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL core_start_pulse: core_start=%b done=%b in_ready=%b, required 0 0 0", core_start, done, in_ready);
    end
    repeat (4) tick();
    core_valid = 1'b1;
    for (int l = 0; l < NO; l++) core_out[l*W +: W] = 16'h0101 + 16'(l);
    tick();
    core_valid = 1'b0;
    for (int l = 0; l < NO; l++) exp_res[l] = 16'h0101 + 16'(l);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_done: done=%b busy=%b error=%b, required 1 0 0", done, busy, error);
    end
    n_tests++;
    if (acc_cnt - a0 != IND || cs_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL accept_count: accepts=%0d core_starts=%0d, required 19 1", acc_cnt - a0, cs_cnt - c0);
    end
    do_read(2'd0, 64'h0104_0103_0102_0101);
    do_read(2'd1, res_word(1));
    do_read(2'd2, 64'h0000_0000_0000_0109);
    do_read(2'd3, 64'h0);
  endtask

  task automatic test_throttle();
    int a0, c0;
    a0 = acc_cnt; c0 = cs_cnt;
    load_job(101, 1, 1'b1, IND, 1'b1);
    n_tests++;
    if (core_start !== 1'b1 || acc_cnt - a0 != IND) begin
      n_fail++;
      $display("FAIL throttle_accepts: core_start=%b accepts=%0d, required 1 19", core_start, acc_cnt - a0);
    end
    n_tests++;
    if (core_in !== exp_core_in()) begin
      n_fail++;
      $display("FAIL throttle_core_in: lane0=%h lane75=%h, required %h %h",
               core_in[15:0], core_in[75*W +: W], exp_in[0], exp_in[75]);
    end
    // Result arrives in the core_start cycle while word 0 is read.
    core_valid = 1'b1;
    for (int l = 0; l < NO; l++) core_out[l*W +: W] = 16'h0A01 + 16'(l);
    rd_en = 1'b1; rd_addr = 2'd0;
    sb_q.push_back(res_word(0));
    tick();
    core_valid = 1'b0; rd_en = 1'b0;
    for (int l = 0; l < NO; l++) exp_res[l] = 16'h0A01 + 16'(l);
    @(negedge clk); #1;
    n_tests++;
    if (sb_q.size() != 0 || done !== 1'b1 || cs_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL same_cycle_capture: pending=%0d done=%b core_starts=%0d, required 0 1 1",
               sb_q.size(), done, cs_cnt - c0);
      sb_q.delete();
    end
    core_valid = 1'b1;
    for (int l = 0; l < NO; l++) core_out[l*W +: W] = 16'hBAD0;
    tick(); tick();
    core_valid = 1'b0;
    do_read(2'd0, res_word(0));
    do_read(2'd1, res_word(1));
    do_read(2'd2, 64'h0000_0000_0000_0A09);
  endtask

  task automatic test_timeout();
    load_job(201, 0, 1'b0, IND, 1'b1);
    n_tests++;
    if (core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_core_start: core_start=%b, required 1", core_start);
    end
    repeat (254) tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: done=%b busy=%b error=%b at RUN cycle 254, required 0 1 0", done, busy, error);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flag: done=%b error=%b busy=%b after 255 RUN cycles, required 1 1 0", done, error, busy);
    end
    do_read(2'd0, res_word(0));
    do_read(2'd2, res_word(2));
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (error !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: error=%b done=%b in_ready=%b, required 0 0 1", error, done, in_ready);
    end
  endtask

  // Continues the job opened at the end of test_timeout, then resets mid-load.
  task automatic test_reset_midload();
    int c0;
    load_job(301, 0, 1'b0, 7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) exp_in[k] = '0;
    for (int k = 0; k < NO; k++) exp_res[k] = '0;
    n_tests++;
    if ({in_ready, core_start, busy, done, error, rd_valid} !== 6'b0 || core_in !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: rdy/cs/busy/done/err/rdv=%b core_in_lane0=%h, required all 0",
               {in_ready, core_start, busy, done, error, rd_valid}, core_in[15:0]);
    end
    tick(); tick();
    rst_n = 1'b1;
    c0 = cs_cnt;
    repeat (5) tick();
    n_tests++;
    if (cs_cnt != c0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: core_starts=%0d busy=%b in_ready=%b, required 0 0 0", cs_cnt - c0, busy, in_ready);
    end
    do_read(2'd0, 64'h0);
    load_job(401, 0, 1'b0, IND, 1'b1);
    n_tests++;
    if (core_start !== 1'b1 || core_in !== exp_core_in()) begin
      n_fail++;
      $display("FAIL rerun_load: core_start=%b lane0=%h, required 1 %h", core_start, core_in[15:0], exp_in[0]);
    end
    core_valid = 1'b1;
    for (int l = 0; l < NO; l++) core_out[l*W +: W] = 16'h0C01 + 16'(l);
    tick();
    core_valid = 1'b0;
    for (int l = 0; l < NO; l++) exp_res[l] = 16'h0C01 + 16'(l);
    n_tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_done: done=%b error=%b, required 1 0", done, error);
    end
    do_read(2'd1, 64'h0C08_0C07_0C06_0C05);
  endtask

  task automatic test_small_params();
    s_start = 1'b1; tick(); s_start = 1'b0;
    n_tests++;
    if (s_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL small_ready: in_ready=%b, required 1", s_in_ready);
    end
    s_in_valid = 1'b1; s_in_data = 64'h1817_1615_1413_1211;
    tick();
    s_in_data = 64'hEEEE_EEEE_EEEE_1A19;
    tick();
    s_in_valid = 1'b0; s_in_data = '0;
    n_tests++;
    if (s_core_start !== 1'b1 || s_core_in !== 80'h1A19_1817_1615_1413_1211) begin
      n_fail++;
      $display("FAIL small_core_in: core_start=%b core_in=%h, required 1 1a191817161514131211", s_core_start, s_core_in);
    end
    s_core_valid = 1'b1; s_core_out = 24'hC3B2A1;
    tick();
    s_core_valid = 1'b0;
    n_tests++;
    if (s_done !== 1'b1 || s_error !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL small_done: done=%b error=%b busy=%b, required 1 0 0", s_done, s_error, s_busy);
    end
    s_rd_en = 1'b1; s_rd_addr = 1'b0;
    tick();
    n_tests++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== 64'h0000_0000_00C3_B2A1) begin
      n_fail++;
      $display("FAIL small_rd0: rd_valid=%b rd_data=%h, required 1 0000000000c3b2a1", s_rd_valid, s_rd_data);
    end
    s_rd_addr = 1'b1;
    tick();
    n_tests++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL small_rd_oob: rd_valid=%b rd_data=%h, required 1 0", s_rd_valid, s_rd_data);
    end
    s_rd_en = 1'b0;
    tick();
    n_tests++;
    if (s_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL small_rd_idle: rd_valid=%b, required 0", s_rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_throttle();
    test_timeout();
    test_reset_midload();
    test_small_params();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
